// File: rtl/dmem_responder_if.sv
// Load/store port bundle between the datapath (master) and the data-memory responder (slave).
interface dmem_responder_if #(
  parameter int BITSIZE = 32
);
  logic [BITSIZE-1:0] addr;
  logic [BITSIZE-1:0] write_data;
  logic               mem_read;
  logic               mem_write;
  logic [2:0]         funct3;
  logic [BITSIZE-1:0] read_data;
  logic               ready;
  logic               error;

  modport master (
    output addr, write_data, mem_read, mem_write, funct3,
    input  read_data, ready, error
  );

  modport slave (
    input  addr, write_data, mem_read, mem_write, funct3,
    output read_data, ready, error
  );
endinterface

// File: rtl/dmem_responder.sv
// Wait-stated byte/half/word data memory for the RISC-V load/store port.
// Optional misalignment trap: define DMEM_MISALIGN_TRAP_EN.
module dmem_responder #(
  parameter int BITSIZE     = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic                clock,
  input  logic                reset,
  dmem_responder_if.slave     bus,
  output logic [1:0]          state_dbg
);

  // Handshake: the initiator raises mem_read/mem_write with addr/write_data/funct3 and
  // holds them until ready pulses for one cycle; inputs are sampled only in S_IDLE, and a
  // request still high in S_IDLE after the response starts the next access.

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WS4 = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [IDX_W+1:0]   addr_q;
  logic [BITSIZE-1:0] wdata_q;
  logic [2:0]         f3_q;
  logic               is_load_q;
  logic               err_q;

  logic               req;
  logic               f3_ok;
  logic               range_err;
  logic               err_new;
  logic [IDX_W+1:0]   addr_al;

  logic [IDX_W-1:0]   idx;
  logic [BITSIZE-1:0] word;
  logic [7:0]         byte_sel;
  logic [15:0]        half_sel;
  logic [BITSIZE-1:0] load_val;
  logic [3:0]         be;
  logic [BITSIZE-1:0] lanes;

  logic [BITSIZE-1:0] mem [DEPTH_WORDS];

  assign req = bus.mem_read | bus.mem_write;

  // Request decode, evaluated on the live inputs and captured only in S_IDLE.
  always_comb begin
    f3_ok     = 1'b0;
    range_err = |bus.addr[BITSIZE-1:IDX_W+2];
    addr_al   = bus.addr[IDX_W+1:0];
    unique case (bus.funct3)
      3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
      3'b100, 3'b101:         f3_ok = ~bus.mem_write;
      default:                f3_ok = 1'b0;
    endcase
    err_new = (bus.mem_read & bus.mem_write) | range_err | ~f3_ok;
`ifdef DMEM_MISALIGN_TRAP_EN
    if ((bus.funct3[1:0] == 2'b01 && bus.addr[0]) ||
        (bus.funct3[1:0] == 2'b10 && bus.addr[1:0] != 2'b00))
      err_new = 1'b1;
`else
    if (bus.funct3[1:0] == 2'b01) addr_al[0]   = 1'b0;
    if (bus.funct3[1:0] == 2'b10) addr_al[1:0] = 2'b00;
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          cnt_d   = WS4;
          state_d = (WS4 == 4'd0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      f3_q      <= '0;
      is_load_q <= 1'b0;
      err_q     <= 1'b0;
    end else if (state_q == S_IDLE && req) begin
      addr_q    <= addr_al;
      wdata_q   <= bus.write_data;
      f3_q      <= bus.funct3;
      is_load_q <= bus.mem_read;
      err_q     <= err_new;
    end
  end

  assign idx      = addr_q[IDX_W+1:2];
  assign word     = mem[idx];
  assign byte_sel = word[{addr_q[1:0], 3'b000} +: 8];
  assign half_sel = word[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    load_val = '0;
    unique case (f3_q)
      3'b000:  load_val = {{(BITSIZE-8){byte_sel[7]}}, byte_sel};
      3'b100:  load_val = {{(BITSIZE-8){1'b0}}, byte_sel};
      3'b001:  load_val = {{(BITSIZE-16){half_sel[15]}}, half_sel};
      3'b101:  load_val = {{(BITSIZE-16){1'b0}}, half_sel};
      3'b010:  load_val = word;
      default: load_val = '0;
    endcase
  end

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    be    = 4'b1111;
    lanes = wdata_q;
    unique case (f3_q[1:0])
      2'b00: begin
        be    = 4'b0001 << addr_q[1:0];
        lanes = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be    = addr_q[1] ? 4'b1100 : 4'b0011;
        lanes = {2{wdata_q[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        lanes = wdata_q;
      end
    endcase
  end

  // Storage has no reset; the reset term drops a store caught by a mid-access reset.
  always_ff @(posedge clock) begin
    if (!reset && state_q == S_RESP && !is_load_q && !err_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= lanes[8*i +: 8];
      end
    end
  end

  assign bus.ready     = (state_q == S_RESP);
  assign bus.error     = (state_q == S_RESP) & err_q;
  assign bus.read_data = (state_q == S_RESP && is_load_q && !err_q) ? load_val : '0;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized scoreboard bench for dmem_responder against a byte-array memory model.
module tb_dmem_responder;

  localparam int W     = 32;
  localparam int DEPTH = 256;
  localparam int WS    = 1;

  logic       clock;
  logic       reset;
  logic [1:0] state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W:0] exp_q[$];
  logic [7:0] mem_b [DEPTH*4];

  dmem_responder_if #(.BITSIZE(W)) bus ();

  dmem_responder #(
    .BITSIZE(W),
    .DEPTH_WORDS(DEPTH),
    .WAIT_STATES(WS)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // reference model: byte-addressed little-endian memory
  task automatic model_access(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd,
                              output logic [W:0] exp);
    logic        err;
    logic [31:0] aa;
    logic [31:0] d;
    int          sz;
    sz  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    err = 1'b0;
    if (rd && wr) err = 1'b1;
    if (a >= DEPTH*4) err = 1'b1;
    if (!((f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) ||
          (!wr && (f3 == 3'd4 || f3 == 3'd5)))) err = 1'b1;
    aa = a;
`ifdef DMEM_MISALIGN_TRAP_EN
    if ((a % sz) != 0) err = 1'b1;
`else
    aa = a - (a % sz);
`endif
    d = '0;
    if (!err && rd) begin
      for (int i = 0; i < sz; i++) d = d | (32'(mem_b[aa+i]) << (8*i));
      if (!f3[2] && sz < 4 && d[8*sz-1]) d = d | (32'hFFFF_FFFF << (8*sz));
    end
    if (!err && wr) begin
      for (int i = 0; i < sz; i++) mem_b[aa+i] = wd[8*i +: 8];
    end
    exp = {err, d};
  endtask

  // driver tasks (called at a negedge, return at a negedge with the bus idle)
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd);
    logic [W:0] e;
    int         lat;
    bit         seen;
    model_access(rd, wr, f3, a, wd, e);
    exp_q.push_back(e);
    bus.addr       = a;
    bus.write_data = wd;
    bus.funct3     = f3;
    bus.mem_read   = rd;
    bus.mem_write  = wr;
    lat  = 0;
    seen = 0;
    while (!seen && lat < 40) begin
      @(negedge clock);
      lat++;
      if (bus.ready) seen = 1;
    end
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    check("latency", 33'(lat), 33'(WS + 1));
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clock);
    check("reset_state", 33'(state_dbg), 33'd0);
    check("reset_outputs", {bus.error, bus.read_data} | 33'(bus.ready), 33'd0);
    reset = 1'b0;
    @(negedge clock);
  endtask

  // store aborted by reset during the wait phase: no Ready, no commit
  task automatic aborted_store(input logic [31:0] a, input logic [31:0] wd);
    bus.addr       = a;
    bus.write_data = wd;
    bus.funct3     = 3'b010;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b1;
    @(negedge clock);
    check("abort_in_wait", 33'(state_dbg), 33'd1);
    reset         = 1'b1;
    bus.mem_write = 1'b0;
    @(negedge clock);
    check("abort_ready", 33'(bus.ready), 33'd0);
    reset = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  task automatic back_to_back(input logic [31:0] a, input int n);
    logic [W:0] e;
    int cyc, last, got;
    for (int i = 0; i < n; i++) begin
      model_access(1'b1, 1'b0, 3'b010, a, 32'd0, e);
      exp_q.push_back(e);
    end
    bus.addr     = a;
    bus.funct3   = 3'b010;
    bus.mem_read = 1'b1;
    cyc  = 0;
    last = 0;
    got  = 0;
    while (got < n && cyc < 200) begin
      @(negedge clock);
      cyc++;
      if (bus.ready) begin
        if (got > 0) check("b2b_period", 33'(cyc - last), 33'(WS + 2));
        last = cyc;
        got++;
        if (got == n) bus.mem_read = 1'b0;
      end
    end
    bus.mem_read = 1'b0;
    check("b2b_count", 33'(got), 33'(n));
    @(negedge clock);
  endtask

  // scoreboard monitor
  always @(negedge clock) begin
    logic [W:0] e;
    if (!reset) begin
      if (bus.ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_ready: got ready=1 expected no response");
        end else begin
          e = exp_q.pop_front();
          check("read_data", {1'b0, bus.read_data}, {1'b0, e[W-1:0]});
          check("error", 33'(bus.error), 33'(e[W]));
        end
      end else begin
        check("idle_outputs", {bus.error, bus.read_data}, 33'd0);
      end
    end
  end

  initial begin
    logic        rd, wr;
    logic [2:0]  f3;
    logic [31:0] a;
    int          r;
    reset          = 1'b1;
    bus.addr       = '0;
    bus.write_data = '0;
    bus.funct3     = '0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    repeat (2) @(negedge clock);
    do_reset();

    // preload every word so all reads have a defined model value
    for (int i = 0; i < DEPTH; i++) access(1'b0, 1'b1, 3'b010, 32'(i*4), $urandom);
    do_reset();

    access(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);
    access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    access(1'b0, 1'b1, 3'b000, 32'h13, 32'h0000_0080);
    access(1'b1, 1'b0, 3'b000, 32'h13, 32'h0);
    access(1'b1, 1'b0, 3'b100, 32'h13, 32'h0);
    access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    access(1'b0, 1'b1, 3'b001, 32'h22, 32'h0000_8234);
    access(1'b1, 1'b0, 3'b001, 32'h22, 32'h0);
    access(1'b1, 1'b0, 3'b101, 32'h22, 32'h0);
    access(1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
    access(1'b1, 1'b0, 3'b010, 32'h11, 32'h0);
    access(1'b1, 1'b0, 3'b010, 32'(DEPTH*4), 32'h0);
    access(1'b1, 1'b1, 3'b010, 32'h10, 32'h1234_5678);
    access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    access(1'b0, 1'b1, 3'b100, 32'h14, 32'h55);
    access(1'b1, 1'b0, 3'b011, 32'h14, 32'h0);
    aborted_store(32'h30, 32'h1);
    access(1'b1, 1'b0, 3'b010, 32'h30, 32'h0);
    back_to_back(32'h10, 4);

    for (int k = 0; k < 120; k++) begin
      r  = $urandom_range(0, 9);
      rd = (r < 4) || (r >= 8);
      wr = (r >= 4) && (r <= 8);
      if ($urandom_range(0, 3) != 0) begin
        r  = $urandom_range(0, 4);
        f3 = (r < 3) ? 3'(r) : 3'(r + 1);
      end else begin
        f3 = 3'($urandom_range(0, 7));
      end
      a = 32'($urandom_range(0, DEPTH*4 - 1));
      if ($urandom_range(0, 9) == 0) a = 32'(DEPTH*4) + 32'($urandom_range(0, 1000));
      access(rd, wr, f3, a, $urandom);
    end

    repeat (3) @(negedge clock);
    check("queue_empty", 33'(exp_q.size()), 33'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
